// File: rtl/shift_sequencer.sv
// Shift-datapath sequencer: sets the input/amount mux selects and steps RegDesloc through LOAD, SHIFT and WRITE.
// Optional macro SHIFT_ZERO_SKIP_EN: a zero shift amount skips the SHIFT step.
module shift_sequencer #(
    parameter int AMT_W = 5,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [AMT_W-1:0] amt_value,
    output logic [1:0]       shiftincontrol,
    output logic [1:0]       shiftamtcontrol,
    output logic [2:0]       shift,
    output logic             shift_wr,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SLLV = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SRLV = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SRAV = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRAM = OP_W'(6);

    localparam logic [2:0] SH_HOLD  = 3'b000;
    localparam logic [2:0] SH_LOAD  = 3'b001;
    localparam logic [2:0] SH_LEFT  = 3'b010;
    localparam logic [2:0] SH_RIGHT = 3'b011;
    localparam logic [2:0] SH_ARITH = 3'b100;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_in_sel;
    logic [1:0] r_amt_sel;
    logic [2:0] r_shift_cmd;
    logic       r_err;
    logic       w_valid_op;
    logic       w_accept;
    logic       w_zero_amt;

    // Returns {input select, amount select} for a valid op.
    function automatic logic [3:0] f_sources(input logic [OP_W-1:0] f_op);
        case (f_op)
            OP_SLL, OP_SRL, OP_SRA:    f_sources = {2'b01, 2'b00};
            OP_SLLV, OP_SRLV, OP_SRAV: f_sources = {2'b01, 2'b01};
            OP_SRAM:                   f_sources = {2'b10, 2'b10};
            default:                   f_sources = {2'b00, 2'b00};
        endcase
    endfunction

    function automatic logic [2:0] f_direction(input logic [OP_W-1:0] f_op);
        case (f_op)
            OP_SLL, OP_SLLV: f_direction = SH_LEFT;
            OP_SRL, OP_SRLV: f_direction = SH_RIGHT;
            default:         f_direction = SH_ARITH;
        endcase
    endfunction

    assign w_valid_op = (op <= OP_SRAM);
    assign w_accept   = (r_state == S_IDLE) && start && w_valid_op;

`ifdef SHIFT_ZERO_SKIP_EN
    assign w_zero_amt = (amt_value == '0);
`else
    logic w_unused_amt;
    assign w_unused_amt = ^amt_value;
    assign w_zero_amt   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_in_sel    <= 2'b00;
            r_amt_sel   <= 2'b00;
            r_shift_cmd <= SH_HOLD;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= (r_state == S_IDLE) && start && !w_valid_op;
            if (w_accept) begin
                {r_in_sel, r_amt_sel} <= f_sources(op);
                r_shift_cmd           <= f_direction(op);
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        shift    = SH_HOLD;
        busy     = 1'b0;
        shift_wr = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_LOAD;
            end
            S_LOAD: begin
                shift  = SH_LOAD;
                busy   = 1'b1;
                w_next = w_zero_amt ? S_WRITE : S_SHIFT;
            end
            S_SHIFT: begin
                shift  = r_shift_cmd;
                busy   = 1'b1;
                w_next = S_WRITE;
            end
            S_WRITE: begin
                busy     = 1'b1;
                shift_wr = 1'b1;
                done     = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign shiftincontrol  = r_in_sel;
    assign shiftamtcontrol = r_amt_sel;
    assign err             = r_err;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multicycle controller for the shift datapath: the shift-input source mux (A / B / MDR), the shift-amount source mux, and the shift register (RegDesloc).
- Accepts one shift command from the main control unit and drives the mux selects and the RegDesloc command through LOAD, SHIFT and WRITE steps.
- Pulses write-back strobe and done when the result is ready.
- Sits between the main control FSM and the shift datapath; the main FSM stalls on busy.

Parameters:
- AMT_W, 5, width of the shift amount (amount value 0..2^AMT_W-1).
- OP_W, 3, width of the shift op code.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  command strobe; sampled only in IDLE.
- op  in  OP_W  shift op: 000 SLL, 001 SRL, 010 SRA, 011 SLLV, 100 SRLV, 101 SRAV, 110 SRAM, 111 reserved.
- amt_value  in  AMT_W  current output of the amount mux (low AMT_W bits); used by the optional feature only.
- shiftincontrol  out  2  input-mux select: 00 A, 01 B, 10 MDR.
- shiftamtcontrol  out  2  amount-mux select: 00 instruction shamt, 01 A[4:0], 10 B[4:0].
- shift  out  3  RegDesloc command: 000 hold, 001 load, 010 left, 011 right logical, 100 right arithmetic.
- shift_wr  out  1  one-cycle write-back strobe for the register-file data mux.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse; coincides with shift_wr.
- err  out  1  one-cycle pulse on a reserved op.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; every output 0, including both select outputs. Reset mid-operation aborts the command; no shift_wr or done is produced.
- State IDLE: shift=000, busy=0.
  - On start=1 with a valid op: latch op, shiftincontrol and shiftamtcontrol, then go to LOAD.
  - Source mapping: SLL/SRL/SRA use in=B, amt=shamt. SLLV/SRLV/SRAV use in=B, amt=A. SRAM uses in=MDR, amt=B, arithmetic right shift.
  - On start=1 with op=111: err=1 for the next cycle, stay IDLE, selects unchanged.
- State LOAD: shift=001, busy=1. Go to SHIFT.
- State SHIFT: shift=010 (left), 011 (logical right) or 100 (arithmetic right), per the latched op. busy=1. Go to WRITE.
- State WRITE: shift=000, shift_wr=1, done=1, busy=1. Go to IDLE.
- Latency: start accepted at edge k; LOAD in cycle k+1, SHIFT in k+2, WRITE/done in k+3. Back-to-back: a new start may be presented the cycle after done, giving one command per 4 cycles.
- Select stability: shiftincontrol and shiftamtcontrol are registered at acceptance and held constant through LOAD, SHIFT and WRITE. They keep their last value in IDLE until the next accepted start.
- start while busy=1 is ignored and not queued.
- start is level-sampled in IDLE: if held high, the next command is accepted on the cycle after returning to IDLE.
- err and done are never asserted in the same cycle.

Optional Feature:
- Macro: SHIFT_ZERO_SKIP_EN.
- Defined: in LOAD, if amt_value==0, the next state is WRITE (skip SHIFT). Zero-amount latency is 2 cycles; done asserts in k+2. The shift value is never 010/011/100 for that command.
- Not defined: amt_value is ignored and every valid command takes the full 3-cycle path.

Test Plan:
1. Reset asserted low mid-SHIFT, then released -> all outputs 0 immediately (async); state IDLE; no done or shift_wr afterwards.
2. start with op=000 (SLL) -> shiftincontrol=01, shiftamtcontrol=00; shift sequence 001, 010, 000; done and shift_wr high exactly in cycle k+3; busy high k+1..k+3.
3. start with op=110 (SRAM) -> shiftincontrol=10, shiftamtcontrol=10, SHIFT cycle shift=100. Also pulse start with op=101 during busy -> ignored; selects unchanged.
4. op=111 -> err=1 for one cycle; busy, shift and done stay 0; selects keep their previous values.
5. SHIFT_ZERO_SKIP_EN defined, op=011 with amt_value=0 -> shift sequence 001, 000; done in k+2. With amt_value=7 -> full 3-cycle path with shift=010.
6. start held high for 10 cycles with op=001 -> two commands complete, done at k+3 and k+7, shift=011 in each SHIFT cycle.
